pcs_receive: RTL and testbench
==============================

# pcs_receive

Receive stage of the 1000BASE-X PCS, directly downstream of the Synchronization block. Consumes the 11-bit SUDI word (code group plus rx_even) and code_sync_status each clock. Decodes 10b code groups to octets and tracks packet framing (idle, /S/, data, /T/R/). Drives GMII-style RXD/RX_DV/RX_ER toward the MAC.

## Interface
- No parameters.
- Clk  in  1  receive clock; one code group per rising edge
- mr_main_reset  in  1  asynchronous, active-low reset
- SUDI  in  11  [10:1] = code group abcdeifghj (a = bit 10, j = bit 1); [0] = rx_even
- code_sync_status  in  1  1 = synchronized (from Synchronization)
- RXD  out  8  decoded octet HGFEDCBA
- RX_DV  out  1  receive data valid
- RX_ER  out  1  receive error / false carrier
- receiving  out  1  high while inside a packet

## Operation
- Decode is combinational: 6b abcdei → EDCBA, 4b fghj → HGF, by full 5b/6b and 3b/4b tables.
  - Both running-disparity encodings are accepted; disparity is not checked.
  - D.x.7 primary and alternate (A7) encodings are both accepted.
  - Any undefined 6b or 4b sub-block makes the group INVALID.
- Special groups, either RD: COMMA = K28.5 (001111 1010 / 110000 0101); S = K27.7; T = K29.7; R = K23.7. Any other K group is treated as INVALID.
- comma_even = COMMA & rx_even.
- States: LINK_FAILED, WAIT_FOR_K, RX_K, IDLE_D, RECEIVE, TRI_RRI.
- Priority rule: code_sync_status=0 in any state → LINK_FAILED, DV=0, RXD=0x00; ER=1 only if the current state is RECEIVE, else 0.
- LINK_FAILED: when sync=1 → WAIT_FOR_K; outputs 0.
- WAIT_FOR_K: comma_even → RX_K, else stay; outputs 0.
- RX_K: valid D → IDLE_D, else → WAIT_FOR_K; outputs 0. /C/ configuration is not supported.
- IDLE_D:
  - comma_even → RX_K, outputs 0.
  - S & rx_even → RECEIVE, DV=1, ER=0, RXD=0x55 (/S/ replaced by preamble).
  - anything else → WAIT_FOR_K, DV=0, ER=1, RXD=0x0E (false carrier).
- RECEIVE:
  - valid D → stay, DV=1, ER=0, RXD=decoded.
  - T → TRI_RRI, outputs 0.
  - comma_even → RX_K, DV=0, ER=1, RXD=0x00 (early end).
  - else (INVALID, S, R, odd COMMA) → stay, DV=1, ER=1, RXD=0x00.
- TRI_RRI:
  - R → WAIT_FOR_K, outputs 0.
  - else → WAIT_FOR_K, DV=0, ER=1, RXD=0x00.
- receiving = 1 when the registered state is RECEIVE or TRI_RRI.

## Timing
- Reset (mr_main_reset=0, asynchronous): state=LINK_FAILED, RXD=0x00, RX_DV=0, RX_ER=0, receiving=0.
- Reset release is sampled on the next Clk edge.
- State, RXD, RX_DV, RX_ER and receiving are all registered.
- Latency: the group present on SUDI before edge k is reflected on outputs immediately after edge k (1 cycle).
- Assertion of reset mid-packet forces outputs to 0 immediately; no RX_ER pulse is generated.
- A loss of sync in the same cycle as T/S/COMMA: the loss-of-sync rule wins.
- Back-to-back packets: S with rx_even=1 is legal in IDLE_D only, so the minimum idle gap is one /I/ after /T/R/.

## Test plan
- Reset, then code_sync_status=1, stream /I2/ (K28.5 even, D16.2 odd) ×4 → RX_DV=0, RX_ER=0, receiving=0 throughout. State reaches IDLE_D by the 3rd edge.
- Idle, then S(even) D0.0 D21.5 D31.7 T R, then K28.5 → outputs 0x55/DV; 0x00/DV; 0xB5/DV; 0xFF/DV; then DV=0, ER=0. receiving is high from S through T, and low after R.
- Mid-packet, inject 111111 0000 (invalid) → one cycle DV=1, ER=1, RXD=0x00; packet continues, and the following D1.0 gives 0x01.
- In IDLE_D, present D5.6 instead of K28.5 or S → one cycle ER=1, DV=0, RXD=0x0E. Then WAIT_FOR_K, and normal idle reacquired after the next K28.5 even.
- Mid-packet, drop code_sync_status for 1 cycle → one cycle ER=1, DV=0, then outputs 0. Rx recovers only via WAIT_FOR_K → RX_K → IDLE_D.
- Mid-packet, T followed by D0.0 instead of R → ER=1, DV=0, RXD=0x00 for one cycle, then WAIT_FOR_K. Separately, assert mr_main_reset mid-packet → all outputs 0 without waiting for Clk.

Source files
------------

// File: rtl/pcs_receive.sv
// 1000BASE-X PCS receive: 8b/10b decode of SUDI code groups and packet framing
// toward a GMII-style RXD/RX_DV/RX_ER interface. All outputs are registered.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// LINK_FAILED | no code sync; outputs held at 0
// WAIT_FOR_K  | hunting for K28.5 on an even code-group position
// RX_K        | got even comma, expecting the data half of an ordered set
// IDLE_D      | between packets; expecting comma or /S/ on even position
// RECEIVE     | inside a packet, forwarding decoded octets
// TRI_RRI     | saw /T/, expecting /R/ to close the packet
module pcs_receive (
    input  logic        Clk,
    input  logic        mr_main_reset,
    input  logic [10:0] SUDI,
    input  logic        code_sync_status,
    output logic [7:0]  RXD,
    output logic        RX_DV,
    output logic        RX_ER,
    output logic        receiving
);

    typedef enum logic [2:0] {
        LINK_FAILED = 3'd0,
        WAIT_FOR_K  = 3'd1,
        RX_K        = 3'd2,
        IDLE_D      = 3'd3,
        RECEIVE     = 3'd4,
        TRI_RRI     = 3'd5
    } state_t;

    // {valid, EDCBA}; both running-disparity forms map to the same value.
    function automatic logic [5:0] dec_6b(input logic [5:0] c);
        case (c)
            6'b100111, 6'b011000: return {1'b1, 5'd0};
            6'b011101, 6'b100010: return {1'b1, 5'd1};
            6'b101101, 6'b010010: return {1'b1, 5'd2};
            6'b110001:            return {1'b1, 5'd3};
            6'b110101, 6'b001010: return {1'b1, 5'd4};
            6'b101001:            return {1'b1, 5'd5};
            6'b011001:            return {1'b1, 5'd6};
            6'b111000, 6'b000111: return {1'b1, 5'd7};
            6'b111001, 6'b000110: return {1'b1, 5'd8};
            6'b100101:            return {1'b1, 5'd9};
            6'b010101:            return {1'b1, 5'd10};
            6'b110100:            return {1'b1, 5'd11};
            6'b001101:            return {1'b1, 5'd12};
            6'b101100:            return {1'b1, 5'd13};
            6'b011100:            return {1'b1, 5'd14};
            6'b010111, 6'b101000: return {1'b1, 5'd15};
            6'b011011, 6'b100100: return {1'b1, 5'd16};
            6'b100011:            return {1'b1, 5'd17};
            6'b010011:            return {1'b1, 5'd18};
            6'b110010:            return {1'b1, 5'd19};
            6'b001011:            return {1'b1, 5'd20};
            6'b101010:            return {1'b1, 5'd21};
            6'b011010:            return {1'b1, 5'd22};
            6'b111010, 6'b000101: return {1'b1, 5'd23};
            6'b110011, 6'b001100: return {1'b1, 5'd24};
            6'b100110:            return {1'b1, 5'd25};
            6'b010110:            return {1'b1, 5'd26};
            6'b110110, 6'b001001: return {1'b1, 5'd27};
            6'b001110:            return {1'b1, 5'd28};
            6'b101110, 6'b010001: return {1'b1, 5'd29};
            6'b011110, 6'b100001: return {1'b1, 5'd30};
            6'b101011, 6'b010100: return {1'b1, 5'd31};
            default:              return 6'd0;
        endcase
    endfunction

    // {valid, HGF}; primary and alternate .7 encodings both decode to 7.
    function automatic logic [3:0] dec_4b(input logic [3:0] c);
        case (c)
            4'b1011, 4'b0100:                   return {1'b1, 3'd0};
            4'b1001:                            return {1'b1, 3'd1};
            4'b0101:                            return {1'b1, 3'd2};
            4'b1100, 4'b0011:                   return {1'b1, 3'd3};
            4'b1101, 4'b0010:                   return {1'b1, 3'd4};
            4'b1010:                            return {1'b1, 3'd5};
            4'b0110:                            return {1'b1, 3'd6};
            4'b1110, 4'b0001, 4'b0111, 4'b1000: return {1'b1, 3'd7};
            default:                            return 4'd0;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  rxd_q, rxd_d;
    logic        dv_q, dv_d;
    logic        er_q, er_d;
    logic        receiving_q, receiving_d;

    logic [5:0]  six_b;
    logic [3:0]  four_b;
    logic        rx_even;
    logic [5:0]  dec6;
    logic [3:0]  dec4;
    logic        k7_four;
    logic        is_kx7;
    logic        is_comma;
    logic        is_s;
    logic        is_t;
    logic        is_r;
    logic        valid_d;
    logic        comma_even;
    logic        s_even;
    logic [7:0]  data_octet;

    assign six_b   = SUDI[10:5];
    assign four_b  = SUDI[4:1];
    assign rx_even = SUDI[0];
    assign dec6    = dec_6b(six_b);
    assign dec4    = dec_4b(four_b);

    // K23/27/29/30.7 share their 6b half with data and their 4b half with A7.
    assign k7_four  = (four_b == 4'b0111) || (four_b == 4'b1000);
    assign is_s     = k7_four && ((six_b == 6'b110110) || (six_b == 6'b001001));
    assign is_t     = k7_four && ((six_b == 6'b101110) || (six_b == 6'b010001));
    assign is_r     = k7_four && ((six_b == 6'b111010) || (six_b == 6'b000101));
    assign is_kx7   = is_s || is_t || is_r ||
                      (k7_four && ((six_b == 6'b011110) || (six_b == 6'b100001)));
    assign is_comma = (SUDI[10:1] == 10'b0011111010) || (SUDI[10:1] == 10'b1100000101);

    assign valid_d    = dec6[5] && dec4[3] && !is_kx7;
    assign data_octet = {dec4[2:0], dec6[4:0]};
    assign comma_even = is_comma && rx_even;
    assign s_even     = is_s && rx_even;

    always_ff @(posedge Clk or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            state_q     <= LINK_FAILED;
            rxd_q       <= 8'h00;
            dv_q        <= 1'b0;
            er_q        <= 1'b0;
            receiving_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rxd_q       <= rxd_d;
            dv_q        <= dv_d;
            er_q        <= er_d;
            receiving_q <= receiving_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!code_sync_status) begin
            state_d = LINK_FAILED;
        end else begin
            case (state_q)
                LINK_FAILED: state_d = WAIT_FOR_K;
                WAIT_FOR_K:  if (comma_even) state_d = RX_K;
                RX_K:        state_d = valid_d ? IDLE_D : WAIT_FOR_K;
                IDLE_D: begin
                    if (comma_even)  state_d = RX_K;
                    else if (s_even) state_d = RECEIVE;
                    else             state_d = WAIT_FOR_K;
                end
                RECEIVE: begin
                    if (valid_d)         state_d = RECEIVE;
                    else if (is_t)       state_d = TRI_RRI;
                    else if (comma_even) state_d = RX_K;
                    else                 state_d = RECEIVE;
                end
                TRI_RRI:     state_d = WAIT_FOR_K;
                default:     state_d = LINK_FAILED;
            endcase
        end
    end

    always_comb begin
        rxd_d = 8'h00;
        dv_d  = 1'b0;
        er_d  = 1'b0;
        if (!code_sync_status) begin
            er_d = (state_q == RECEIVE);
        end else begin
            case (state_q)
                IDLE_D: begin
                    if (comma_even) begin
                        er_d = 1'b0;
                    end else if (s_even) begin
                        dv_d  = 1'b1;
                        rxd_d = 8'h55;
                    end else begin
                        er_d  = 1'b1;
                        rxd_d = 8'h0E;
                    end
                end
                RECEIVE: begin
                    if (valid_d) begin
                        dv_d  = 1'b1;
                        rxd_d = data_octet;
                    end else if (is_t) begin
                        dv_d = 1'b0;
                    end else if (comma_even) begin
                        er_d = 1'b1;
                    end else begin
                        dv_d = 1'b1;
                        er_d = 1'b1;
                    end
                end
                TRI_RRI:  er_d = !is_r;
                default:  er_d = 1'b0;
            endcase
        end
        receiving_d = (state_d == RECEIVE) || (state_d == TRI_RRI);
    end

    assign RXD       = rxd_q;
    assign RX_DV     = dv_q;
    assign RX_ER     = er_q;
    assign receiving = receiving_q;

endmodule

// File: tb/tb_pcs_receive.sv
// Directed bench for pcs_receive: a vector table streamed one code group per
// clock, plus hand sequences around asynchronous reset.
module tb_pcs_receive;

    logic        Clk = 1'b0;
    logic        mr_main_reset;
    logic [10:0] SUDI;
    logic        code_sync_status;
    logic [7:0]  RXD;
    logic        RX_DV;
    logic        RX_ER;
    logic        receiving;

    pcs_receive dut (
        .Clk              (Clk),
        .mr_main_reset    (mr_main_reset),
        .SUDI             (SUDI),
        .code_sync_status (code_sync_status),
        .RXD              (RXD),
        .RX_DV            (RX_DV),
        .RX_ER            (RX_ER),
        .receiving        (receiving)
    );

    always #5 Clk = ~Clk;

    localparam logic [9:0] K28P5   = 10'b001111_1010;
    localparam logic [9:0] K28P5_P = 10'b110000_0101;
    localparam logic [9:0] D16P2   = 10'b011011_0101;
    localparam logic [9:0] S_N     = 10'b110110_1000;
    localparam logic [9:0] S_P     = 10'b001001_0111;
    localparam logic [9:0] T_N     = 10'b101110_1000;
    localparam logic [9:0] T_P     = 10'b010001_0111;
    localparam logic [9:0] R_N     = 10'b111010_1000;
    localparam logic [9:0] R_P     = 10'b000101_0111;
    localparam logic [9:0] K30P7   = 10'b011110_1000;
    localparam logic [9:0] INV     = 10'b111111_0000;
    localparam logic [9:0] D0P0    = 10'b100111_0100;
    localparam logic [9:0] D0P0_P  = 10'b011000_1011;
    localparam logic [9:0] D1P0    = 10'b011101_0100;
    localparam logic [9:0] D3P1    = 10'b110001_1001;
    localparam logic [9:0] D5P6    = 10'b101001_0110;
    localparam logic [9:0] D10P2   = 10'b010101_0101;
    localparam logic [9:0] D15P3   = 10'b010111_0011;
    localparam logic [9:0] D17A7   = 10'b100011_0111;
    localparam logic [9:0] D21P5   = 10'b101010_1010;
    localparam logic [9:0] D24P4   = 10'b001100_1101;
    localparam logic [9:0] D28P1   = 10'b001110_1001;
    localparam logic [9:0] D30P6   = 10'b100001_0110;
    localparam logic [9:0] D31P7   = 10'b101011_0001;

    typedef struct packed {
        logic [9:0] code;
        logic       ev;
        logic       sync;
        logic [7:0] rxd;
        logic       dv;
        logic       er;
        logic       recv;
    } vec_t;

    vec_t  vecs[$];
    string names[$];
    int    checks = 0;
    int    errors = 0;

    task automatic add(input logic [9:0] code, input logic ev, input logic sync,
                       input logic [7:0] rxd, input logic dv, input logic er,
                       input logic recv, input string name);
        vec_t v;
        v.code = code; v.ev = ev; v.sync = sync;
        v.rxd = rxd; v.dv = dv; v.er = er; v.recv = recv;
        vecs.push_back(v);
        names.push_back(name);
    endtask

    task automatic check_out(input string name, input logic [7:0] rxd,
                             input logic dv, input logic er, input logic recv);
        checks++;
        if ({RXD, RX_DV, RX_ER, receiving} !== {rxd, dv, er, recv}) begin
            errors++;
            $display("FAIL %s: got rxd=%h dv=%b er=%b recv=%b, expected rxd=%h dv=%b er=%b recv=%b",
                     name, RXD, RX_DV, RX_ER, receiving, rxd, dv, er, recv);
        end
    endtask

    task automatic apply(input logic [9:0] code, input logic ev, input logic sync,
                         input logic [7:0] rxd, input logic dv, input logic er,
                         input logic recv, input string name);
        @(negedge Clk);
        SUDI = {code, ev};
        code_sync_status = sync;
        @(posedge Clk);
        #1;
        check_out(name, rxd, dv, er, recv);
    endtask

    initial begin
        // idle acquisition: IDLE_D reached on the third edge
        add(D16P2,   1'b0, 1'b1, 8'h00, 0, 0, 0, "acq_lf");
        add(K28P5,   1'b1, 1'b1, 8'h00, 0, 0, 0, "acq_rxk");
        add(D16P2,   1'b0, 1'b1, 8'h00, 0, 0, 0, "acq_idle");
        add(K28P5,   1'b1, 1'b1, 8'h00, 0, 0, 0, "i2_k_1");
        add(D16P2,   1'b0, 1'b1, 8'h00, 0, 0, 0, "i2_d_1");
        add(K28P5,   1'b1, 1'b1, 8'h00, 0, 0, 0, "i2_k_2");
        add(D16P2,   1'b0, 1'b1, 8'h00, 0, 0, 0, "i2_d_2");
        // basic packet
        add(S_N,     1'b1, 1'b1, 8'h55, 1, 0, 1, "pkt1_s");
        add(D0P0,    1'b0, 1'b1, 8'h00, 1, 0, 1, "pkt1_d0.0");
        add(D21P5,   1'b1, 1'b1, 8'hB5, 1, 0, 1, "pkt1_d21.5");
        add(D31P7,   1'b0, 1'b1, 8'hFF, 1, 0, 1, "pkt1_d31.7");
        add(T_N,     1'b1, 1'b1, 8'h00, 0, 0, 1, "pkt1_t");
        add(R_P,     1'b0, 1'b1, 8'h00, 0, 0, 0, "pkt1_r");
        add(K28P5,   1'b1, 1'b1, 8'h00, 0, 0, 0, "pkt1_k");
        add(D16P2,   1'b0, 1'b1, 8'h00, 0, 0, 0, "pkt1_idle");
        // packet with decode variety and in-packet errors
        add(S_N,     1'b1, 1'b1, 8'h55, 1, 0, 1, "pkt2_s");
        add(D10P2,   1'b0, 1'b1, 8'h4A, 1, 0, 1, "d10.2");
        add(INV,     1'b1, 1'b1, 8'h00, 1, 1, 1, "invalid");
        add(D1P0,    1'b0, 1'b1, 8'h01, 1, 0, 1, "d1.0_after");
        add(D3P1,    1'b1, 1'b1, 8'h23, 1, 0, 1, "d3.1");
        add(D24P4,   1'b0, 1'b1, 8'h98, 1, 0, 1, "d24.4_rdp");
        add(D15P3,   1'b1, 1'b1, 8'h6F, 1, 0, 1, "d15.3");
        add(D30P6,   1'b0, 1'b1, 8'hDE, 1, 0, 1, "d30.6_rdp");
        add(D28P1,   1'b1, 1'b1, 8'h3C, 1, 0, 1, "d28.1");
        add(D17A7,   1'b0, 1'b1, 8'hF1, 1, 0, 1, "d17.a7");
        add(D0P0_P,  1'b1, 1'b1, 8'h00, 1, 0, 1, "d0.0_rdp");
        add(K28P5,   1'b0, 1'b1, 8'h00, 1, 1, 1, "odd_comma");
        add(K30P7,   1'b1, 1'b1, 8'h00, 1, 1, 1, "k30.7");
        add(S_N,     1'b0, 1'b1, 8'h00, 1, 1, 1, "s_in_pkt");
        add(R_N,     1'b1, 1'b1, 8'h00, 1, 1, 1, "r_in_pkt");
        add(T_P,     1'b0, 1'b1, 8'h00, 0, 0, 1, "pkt2_t");
        add(D0P0,    1'b1, 1'b1, 8'h00, 0, 1, 0, "t_no_r");
        add(K28P5,   1'b0, 1'b1, 8'h00, 0, 0, 0, "wfk_oddk");
        add(K28P5_P, 1'b1, 1'b1, 8'h00, 0, 0, 0, "wfk_k_rdp");
        add(D16P2,   1'b0, 1'b1, 8'h00, 0, 0, 0, "reacq_idle");
        // false carrier
        add(D5P6,    1'b1, 1'b1, 8'h0E, 0, 1, 0, "false_car");
        add(D16P2,   1'b0, 1'b1, 8'h00, 0, 0, 0, "fc_wfk");
        add(K28P5,   1'b1, 1'b1, 8'h00, 0, 0, 0, "fc_rxk");
        add(D16P2,   1'b0, 1'b1, 8'h00, 0, 0, 0, "fc_idle");
        add(S_N,     1'b0, 1'b1, 8'h0E, 0, 1, 0, "s_odd_fc");
        add(K28P5,   1'b1, 1'b1, 8'h00, 0, 0, 0, "so_rxk");
        add(D16P2,   1'b0, 1'b1, 8'h00, 0, 0, 0, "so_idle");
        add(K28P5,   1'b1, 1'b1, 8'h00, 0, 0, 0, "rxk_a");
        add(K28P5,   1'b1, 1'b1, 8'h00, 0, 0, 0, "rxk_k_wfk");
        add(K28P5_P, 1'b1, 1'b1, 8'h00, 0, 0, 0, "rxk_b");
        add(D16P2,   1'b0, 1'b1, 8'h00, 0, 0, 0, "rxk_idle");
        // early end by even comma
        add(S_N,     1'b1, 1'b1, 8'h55, 1, 0, 1, "pkt3_s");
        add(D21P5,   1'b0, 1'b1, 8'hB5, 1, 0, 1, "pkt3_d");
        add(K28P5,   1'b1, 1'b1, 8'h00, 0, 1, 0, "early_end");
        add(D16P2,   1'b0, 1'b1, 8'h00, 0, 0, 0, "ee_idle");
        // loss of sync mid-packet and coincident with R / S
        add(S_P,     1'b1, 1'b1, 8'h55, 1, 0, 1, "pkt4_s_rdp");
        add(D1P0,    1'b0, 1'b1, 8'h01, 1, 0, 1, "pkt4_d");
        add(D0P0,    1'b1, 1'b0, 8'h00, 0, 1, 0, "sync_loss");
        add(D16P2,   1'b0, 1'b1, 8'h00, 0, 0, 0, "sl_wfk");
        add(K28P5,   1'b1, 1'b1, 8'h00, 0, 0, 0, "sl_rxk");
        add(D16P2,   1'b0, 1'b1, 8'h00, 0, 0, 0, "sl_idle");
        add(S_N,     1'b1, 1'b1, 8'h55, 1, 0, 1, "pkt5_s");
        add(T_N,     1'b0, 1'b1, 8'h00, 0, 0, 1, "pkt5_t");
        add(R_N,     1'b1, 1'b0, 8'h00, 0, 0, 0, "loss_on_r");
        add(D16P2,   1'b0, 1'b1, 8'h00, 0, 0, 0, "lr_wfk");
        add(K28P5,   1'b1, 1'b1, 8'h00, 0, 0, 0, "lr_rxk");
        add(D16P2,   1'b0, 1'b1, 8'h00, 0, 0, 0, "lr_idle");
        add(S_N,     1'b1, 1'b0, 8'h00, 0, 0, 0, "loss_on_s");
        add(D16P2,   1'b0, 1'b1, 8'h00, 0, 0, 0, "ls_wfk");

        mr_main_reset    = 1'b0;
        SUDI             = 11'd0;
        code_sync_status = 1'b0;
        #2;
        check_out("reset_async", 8'h00, 0, 0, 0);
        @(posedge Clk);
        #1;
        check_out("reset_held", 8'h00, 0, 0, 0);
        @(negedge Clk);
        mr_main_reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].code, vecs[i].ev, vecs[i].sync,
                  vecs[i].rxd, vecs[i].dv, vecs[i].er, vecs[i].recv, names[i]);
        end

        // reset asserted mid-packet clears outputs without a clock edge
        apply(K28P5, 1'b1, 1'b1, 8'h00, 0, 0, 0, "mr_rxk");
        apply(D16P2, 1'b0, 1'b1, 8'h00, 0, 0, 0, "mr_idle");
        apply(S_N,   1'b1, 1'b1, 8'h55, 1, 0, 1, "mr_s");
        apply(D21P5, 1'b0, 1'b1, 8'hB5, 1, 0, 1, "mr_d");
        @(negedge Clk);
        SUDI = {D31P7, 1'b1};
        mr_main_reset = 1'b0;
        #1;
        check_out("mr_async_clr", 8'h00, 0, 0, 0);
        @(posedge Clk);
        #1;
        check_out("mr_held", 8'h00, 0, 0, 0);
        @(negedge Clk);
        mr_main_reset = 1'b1;
        apply(D16P2, 1'b0, 1'b1, 8'h00, 0, 0, 0, "mr_rel_wfk");
        apply(K28P5, 1'b1, 1'b1, 8'h00, 0, 0, 0, "mr_rel_rxk");
        apply(D16P2, 1'b0, 1'b1, 8'h00, 0, 0, 0, "mr_rel_idle");
        apply(S_N,   1'b1, 1'b1, 8'h55, 1, 0, 1, "mr_rel_s");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
